// File: rtl/cordic_gain_comp.sv
// cordic_gain_comp: bit-serial 1/K gain compensation after the last CORDIC
// vectoring stage. X_in is multiplied by K_INV / 2^FRAC with one shift-add
// per constant bit; the result and the registered Y residual are offered on a
// valid/ready handshake.
// Ports: clk, rst (async, active high); in_valid/in_ready with X_in, Y_in;
// out_valid/out_ready with mag_out, Y_res.
// Build option: define CORDIC_GAIN_COMP_ROUND_EN to round half toward +inf
// instead of flooring the scaled result.
module cordic_gain_comp #(
    parameter int W     = 15,
    parameter int FRAC  = 14,
    parameter int K_INV = 9949
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] X_in,
    input  logic signed [W-1:0] Y_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] mag_out,
    output logic signed [W-1:0] Y_res
);

    localparam int CW = $clog2(FRAC);
    localparam int AW = 2 * W;
    localparam logic [FRAC-1:0] KB = FRAC'(K_INV);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [AW-1:0] mcand;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_nxt;
    logic signed [AW-1:0] acc_rnd;
    logic signed [AW-1:0] acc_sh;
    logic        [CW-1:0] cnt;
    logic                 last;
    logic signed [W-1:0]  mag_d;
    logic                 unused_hi;

    assign in_ready = (state == IDLE);
    assign last     = (cnt == CW'(FRAC - 1));

    always_comb begin
        acc_nxt = acc;
        if (KB[cnt]) begin
            acc_nxt = acc + (mcand << cnt);
        end
    end

`ifdef CORDIC_GAIN_COMP_ROUND_EN
    assign acc_rnd = acc_nxt + AW'(1 << (FRAC - 1));
`else
    assign acc_rnd = acc_nxt;
`endif

    // Result always fits in W bits since K_INV < 2^FRAC; upper bits are
    // pure sign copies.
    assign acc_sh    = acc_rnd >>> FRAC;
    assign mag_d     = acc_sh[W-1:0];
    assign unused_hi = ^acc_sh[AW-1:W];

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = MUL;
            MUL:  if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mcand     <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            mag_out   <= '0;
            Y_res     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                mcand <= {{W{X_in[W-1]}}, X_in};
                Y_res <= Y_in;
                acc   <= '0;
                cnt   <= '0;
            end
            if (state == MUL) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
                if (last) begin
                    mag_out   <= mag_d;
                    out_valid <= 1'b1;
                end
            end
            if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_gain_comp.sv
// tb_cordic_gain_comp: randomized and directed bench for cordic_gain_comp
// against an arithmetic model of X * K_INV / 2^FRAC.
module tb_cordic_gain_comp;

    localparam int W    = 15;
    localparam int FRAC = 14;
    localparam int KINV = 9949;
    localparam int LAT  = FRAC + 1;
    localparam int II   = FRAC + 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] X_in = '0;
    logic signed [W-1:0] Y_in = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] mag_out;
    logic signed [W-1:0] Y_res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cordic_gain_comp #(.W(W), .FRAC(FRAC), .K_INV(KINV)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .X_in     (X_in),
        .Y_in     (Y_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mag_out  (mag_out),
        .Y_res    (Y_res)
    );

    function automatic int ref_mag(input int x);
        longint p;
        p = longint'(x) * longint'(KINV);
`ifdef CORDIC_GAIN_COMP_ROUND_EN
        p = p + (longint'(1) << (FRAC - 1));
`endif
        return int'(p >>> FRAC);
    endfunction

    // Drives one operand from IDLE, waits for the result, holds out_ready
    // low for 'stall' cycles, then completes the handshake.
    task automatic do_op(input int x, input int y, input int stall,
                         output int m, output int yr, output int lat,
                         output bit ok);
        ok = 1'b0;
        m  = 0;
        yr = 0;
        in_valid  = 1'b1;
        X_in      = W'(x);
        Y_in      = W'(y);
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid = 1'b0;
        X_in     = W'($urandom);
        Y_in     = W'($urandom);
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (out_valid) ok = 1'b1;
        m  = int'(mag_out);
        yr = int'(Y_res);
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || mag_out !== '0 || Y_res !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ov=%b mag=%0d yres=%0d want 0/0/0",
                     out_valid, mag_out, Y_res);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rounding();
        int m, yr, lat;
        bit ok;
        do_op(3, 7, 0, m, yr, lat, ok);
        checks++;
`ifdef CORDIC_GAIN_COMP_ROUND_EN
        if (!ok || m != 2) begin
`else
        if (!ok || m != 1) begin
`endif
            errors++;
            $display("FAIL round_x3: got %0d ok=%0d", m, ok);
        end
        checks++;
        if (yr != 7) begin
            errors++;
            $display("FAIL round_yres: got %0d want 7", yr);
        end
    endtask

    task automatic test_reset_mid_mul();
        int m, yr, lat;
        bit ok;
        in_valid = 1'b1;
        X_in     = W'(1000);
        Y_in     = W'(9);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || mag_out !== '0 || Y_res !== '0) begin
            errors++;
            $display("FAIL midmul_reset: ov=%b mag=%0d yres=%0d want 0",
                     out_valid, mag_out, Y_res);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midmul_after: in_ready=%b ov=%b want 1/0",
                     in_ready, out_valid);
        end
        do_op(1000, 1, 0, m, yr, lat, ok);
        checks++;
        if (!ok || m != 607 || lat != LAT) begin
            errors++;
            $display("FAIL midmul_next: mag=%0d lat=%0d want 607 lat %0d",
                     m, lat, LAT);
        end
    endtask

    task automatic test_extremes();
        int xs[3] = '{16383, -16384, -3};
        int want[3] = '{9948, -9949, -2};
        int m, yr, lat;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            do_op(xs[i], -i, 0, m, yr, lat, ok);
            checks++;
            if (!ok || m != want[i] || m != ref_mag(xs[i])) begin
                errors++;
                $display("FAIL extreme x=%0d: got %0d want %0d",
                         xs[i], m, want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        bit bad;
        in_valid  = 1'b1;
        X_in      = W'(1000);
        Y_in      = W'(-5);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL bp_valid: out_valid never rose");
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mag_out !== W'(607) || Y_res !== W'(-5) ||
                out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
            in_valid = (i == 8);
            X_in     = W'(123);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: mag=%0d yres=%0d ov=%b rdy=%b",
                     mag_out, Y_res, out_valid, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: ov=%b rdy=%b want 0/1",
                     out_valid, in_ready);
        end
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_ignored: spurious result from extra pulse");
        end
    endtask

    task automatic test_back_to_back();
        int xq[$];
        int yq[$];
        int sent, got, last_t, ex;
        bit bad;
        for (int i = 0; i < 4; i++) begin
            xq.push_back($urandom_range(32767) - 16384);
            yq.push_back($urandom_range(32767) - 16384);
        end
        sent = 0;
        got = 0;
        last_t = -1;
        bad = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && got < 4; t++) begin
            if (out_valid) begin
                ex = ref_mag(xq[got]);
                if (int'(mag_out) != ex || int'(Y_res) != yq[got]) bad = 1'b1;
                if (last_t >= 0 && t - last_t != II) bad = 1'b1;
                last_t = t;
                got++;
            end
            if (in_ready && sent < 4) begin
                in_valid = 1'b1;
                X_in = W'(xq[sent]);
                Y_in = W'(yq[sent]);
                sent++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bad || got != 4) begin
            errors++;
            $display("FAIL back_to_back: got %0d results bad=%0d want 4",
                     got, bad);
        end
    endtask

    task automatic test_random();
        int x, y, m, yr, lat;
        bit ok;
        for (int i = 0; i < 20; i++) begin
            x = $urandom_range(32767) - 16384;
            y = $urandom_range(32767) - 16384;
            do_op(x, y, $urandom_range(3), m, yr, lat, ok);
            checks++;
            if (!ok || m != ref_mag(x) || yr != y || lat != LAT) begin
                errors++;
                $display("FAIL random x=%0d: mag=%0d want %0d y=%0d/%0d lat=%0d",
                         x, m, ref_mag(x), yr, y, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_reset_mid_mul();
        test_extremes();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
